// File: rtl/toggle_evt_pkg.sv
// Shared types and defaults for the toggle event decoder.
package toggle_evt_pkg;

   typedef enum logic {
      ARM = 1'b0,
      RUN = 1'b1
   } evt_state_t;

   localparam int unsigned SYNC_STAGES_DEF = 2;
   localparam int unsigned CNT_W_DEF       = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to 0.
module sync_chain #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] ff;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ff <= '0;
      else      ff <= {ff[DEPTH-2:0], d};
   end

   assign q = ff[DEPTH-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Turns level changes on an asynchronous toggle line into strobes and a
// saturating pending-event count with a sticky overflow flag.
module toggle_event_decoder
   import toggle_evt_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgl_in,
   input  logic             enable,
   output logic             evt_pulse,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [CNT_W-1:0] pend_cnt,
   output logic             overflow,
   input  logic             ovf_clr
);

   localparam int unsigned      ARM_W    = $clog2(SYNC_STAGES + 1);
   localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
   localparam logic [ARM_W-1:0] ARM_ONE  = {{(ARM_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   evt_state_t       state, next_state;
   logic [ARM_W-1:0] arm_cnt;
   logic             sync_q;
   logic             prev_q;
   logic             edge_acc;
   logic             pop;
   logic [CNT_W-1:0] pend_nxt;
   logic             ovf_set;

   sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (tgl_in),
      .q   (sync_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ARM;
      else      state <= next_state;
   end

   // ARM waits for the synchronizer to fill so a level present at reset release is absorbed.
   always_comb begin
      next_state = state;
      edge_acc   = 1'b0;
      case (state)
         ARM: if (arm_cnt == ARM_LAST) next_state = RUN;
         RUN: edge_acc = enable && (sync_q != prev_q);
         default: next_state = ARM;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         arm_cnt   <= '0;
         prev_q    <= 1'b0;
         evt_pulse <= 1'b0;
      end else begin
         if (state == ARM && arm_cnt != ARM_LAST) arm_cnt <= arm_cnt + ARM_ONE;
         prev_q    <= sync_q;
         evt_pulse <= edge_acc;
      end
   end

   assign evt_valid = (pend_cnt != '0);
   assign pop       = evt_valid && evt_ready;

   // A simultaneous push and pop cancel out, even at full count.
   always_comb begin
      pend_nxt = pend_cnt;
      ovf_set  = 1'b0;
      if (evt_pulse && !pop) begin
         if (pend_cnt == CNT_MAX) ovf_set  = 1'b1;
         else                     pend_nxt = pend_cnt + CNT_ONE;
      end else if (!evt_pulse && pop) begin
         pend_nxt = pend_cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         pend_cnt <= pend_nxt;
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder with a pend_cnt scoreboard per accepted event.
module tb_toggle_event_decoder;
   import toggle_evt_pkg::*;

   localparam int unsigned SS   = 2;
   localparam int unsigned CW   = 4;
   localparam int          CMAX = 15;

   logic          clk = 1'b0;
   logic          rst, tgl_in, enable, evt_ready, ovf_clr;
   logic          evt_pulse, evt_valid, overflow;
   logic [CW-1:0] pend_cnt;

   int errors = 0;
   int checks = 0;
   int model_cnt = 0;
   bit model_ovf = 1'b0;
   int sb_q[$];

   toggle_event_decoder #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .tgl_in    (tgl_in),
      .enable    (enable),
      .evt_pulse (evt_pulse),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .pend_cnt  (pend_cnt),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Toggle once and watch four cycles; an accepted event pushes its expected count.
   task automatic toggle_chk(input string tag, input bit exp_pulse);
      int npulse = 0;
      int lat = 0;
      tgl_in = ~tgl_in;
      if (exp_pulse) begin
         if (model_cnt == CMAX) model_ovf = 1'b1;
         else                   model_cnt++;
         sb_q.push_back(model_cnt);
      end
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (evt_pulse === 1'b1) begin
            npulse++;
            lat = i;
         end
      end
      chk({tag, " pulses"}, npulse, exp_pulse ? 1 : 0);
      if (exp_pulse) begin
         chk({tag, " latency"}, lat, SS + 1);
         chk({tag, " pend"}, pend_cnt, sb_q.pop_front());
      end else begin
         chk({tag, " pend"}, pend_cnt, model_cnt);
      end
      chk({tag, " ovf"}, overflow, model_ovf);
   endtask

   task automatic pop_n(input int n);
      evt_ready = 1'b1;
      repeat (n) begin
         @(negedge clk);
         if (model_cnt > 0) model_cnt--;
      end
      evt_ready = 1'b0;
   endtask

   task automatic quiet_window(input string tag);
      int npulse = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (evt_pulse !== 1'b0) npulse++;
      end
      chk({tag, " pulses"}, npulse, 0);
      chk({tag, " pend"}, pend_cnt, model_cnt);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; tgl_in = 1'b1; enable = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst pend", pend_cnt, model_cnt);
      chk("rst pulse", evt_pulse, 0);
      chk("rst ovf", overflow, model_ovf);
      chk("rst valid", evt_valid, 0);
      chk("rst state", dut.state, ARM);

      rst = 1'b1;
      quiet_window("held level");
      chk("run state", dut.state, RUN);

      toggle_chk("first", 1'b1);
      chk("first valid", evt_valid, 1);
      pop_n(1);
      chk("pop pend", pend_cnt, model_cnt);
      chk("pop valid", evt_valid, 0);
      pop_n(3);
      chk("idle ready pend", pend_cnt, model_cnt);

      toggle_chk("single", 1'b1);
      chk("single valid", evt_valid, 1);
      pop_n(1);

      for (int i = 0; i < 16; i++) toggle_chk($sformatf("fill%0d", i), 1'b1);

      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      model_ovf = 1'b0;
      chk("ovf clr", overflow, model_ovf);
      chk("ovf clr pend", pend_cnt, model_cnt);

      // Pulse and pop land on the same edge at full count.
      tgl_in = ~tgl_in;
      sb_q.push_back(model_cnt);
      repeat (3) @(negedge clk);
      chk("simul pulse", evt_pulse, 1);
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      chk("simul pend", pend_cnt, sb_q.pop_front());
      chk("simul ovf", overflow, model_ovf);

      pop_n(20);
      chk("drain pend", pend_cnt, model_cnt);

      enable = 1'b0;
      for (int i = 0; i < 3; i++) toggle_chk($sformatf("gated%0d", i), 1'b0);
      enable = 1'b1;
      toggle_chk("ungated", 1'b1);

      for (int i = 0; i < 15; i++) toggle_chk($sformatf("refill%0d", i), 1'b1);
      pop_n(10);
      chk("pre-rst pend", pend_cnt, model_cnt);
      chk("pre-rst ovf", overflow, model_ovf);

      rst = 1'b0;
      tgl_in = ~tgl_in;
      model_cnt = 0;
      model_ovf = 1'b0;
      sb_q.delete();
      #1;
      chk("async pend", pend_cnt, model_cnt);
      chk("async ovf", overflow, model_ovf);
      chk("async valid", evt_valid, 0);
      chk("async state", dut.state, ARM);
      @(negedge clk);
      rst = 1'b1;
      quiet_window("post-rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/toggle_event_decoder.md
TOGGLE_EVENT_DECODER -- requirements
Module: toggle_event_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on tgl_in; legal values are 2 or more.
REQ-002 SHALL have parameter CNT_W, default 4, width of the pending-event counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock, with all state on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port tgl_in, input, 1 bit: toggle line from a remote toggle-flop sender; each level change is one event; asynchronous to clk.
REQ-006 SHALL have port enable, input, 1 bit: when low, detected edges are discarded.
REQ-007 SHALL have port evt_pulse, output, 1 bit: one-cycle strobe per accepted edge.
REQ-008 SHALL have port evt_valid, output, 1 bit: at least one event is pending.
REQ-009 SHALL have port evt_ready, input, 1 bit: consumer pops one event.
REQ-010 SHALL have port pend_cnt, output, CNT_W bits: number of pending events.
REQ-011 SHALL have port overflow, output, 1 bit: sticky event-lost flag.
REQ-012 SHALL have port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-013 SHALL pass tgl_in through a SYNC_STAGES-flop synchronizer; sync_q is the last stage output.
REQ-014 SHALL implement a 2-state FSM with states ARM and RUN.
- ARM is entered on reset.
- In ARM, prev_q loads sync_q every cycle, no events are produced, and an arm counter runs.
- The FSM moves to RUN after SYNC_STAGES+1 cycles in ARM.
- RUN is held until the next reset.
REQ-015 SHALL, in RUN, load prev_q with sync_q every cycle; an edge is sync_q != prev_q.
REQ-016 SHALL assert evt_pulse for exactly one cycle per edge when enable=1; latency is SYNC_STAGES+1 clk edges from a stable tgl_in change.
REQ-017 SHALL, on an edge with enable=0, produce no pulse and no count change; prev_q still tracks.
REQ-018 SHALL drive evt_valid = (pend_cnt != 0), combinationally from the counter register.
REQ-019 SHALL define pop as evt_valid && evt_ready.
- Pop decrements pend_cnt by 1.
- evt_ready with evt_valid=0 is ignored.
REQ-020 SHALL increment pend_cnt by 1 on evt_pulse.
REQ-021 SHALL leave pend_cnt unchanged and overflow unchanged when evt_pulse and pop occur in the same cycle, including at full count.
REQ-022 SHALL, on evt_pulse at pend_cnt = 2^CNT_W-1 with no pop, drop the event, hold the count, and set overflow on the next edge.
REQ-023 SHALL clear overflow on ovf_clr; if a new overflow occurs in the same cycle, set wins.
REQ-024 SHALL never wrap pend_cnt in either direction.

Reset
REQ-025 SHALL, while rst=0, asynchronously force:
- synchronizer flops and prev_q to 0;
- state to ARM and arm counter to 0;
- evt_pulse, pend_cnt and overflow to 0.
REQ-026 SHALL, on reset asserted mid-operation, lose all pending events and the overflow flag; no pulse is emitted on release.
REQ-027 SHALL NOT generate an event after reset release for a tgl_in level held at 1; ARM absorbs it.

Structure
REQ-028 SHALL place in shared package toggle_evt_pkg:
- the FSM state enum (ARM, RUN);
- default constants SYNC_STAGES_DEF=2 and CNT_W_DEF=4.
REQ-029 SHALL implement the synchronizer as sub-module sync_chain, parameterized by depth, with asynchronous active-low reset to 0.
REQ-030 SHALL keep the FSM, edge detect, counter and overflow logic in toggle_event_decoder.

Verification
REQ-031 Post-reset level: tgl_in=1 held through reset release -> no evt_pulse and pend_cnt=0 for 20 cycles.
REQ-032 Single toggle: RUN, enable=1, tgl_in 0->1, evt_ready=0 -> evt_pulse 3 cycles later (SYNC_STAGES=2), then pend_cnt=1 and evt_valid=1.
REQ-033 Fill and overflow: CNT_W=4, evt_ready=0, 16 toggles spaced 4 cycles apart -> pend_cnt saturates at 15, overflow=1 after the 16th; then ovf_clr pulse -> overflow=0.
REQ-034 Simultaneous events: pend_cnt=15 with evt_pulse and pop in the same cycle -> pend_cnt stays 15 and overflow stays 0.
REQ-035 Enable gating: enable=0 during 3 toggles, then enable=1 for 1 toggle -> exactly one evt_pulse and pend_cnt=1.
REQ-036 Reset mid-operation: rst=0 pulse with pend_cnt=5 and overflow=1 -> both 0 immediately (asynchronously), state ARM, no pulse after release.
